// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI receiver: FSM encoding, SPI mode
// constants ({CKP,CPH}) and the sample-edge selection rule.
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT
    } state_t;

    localparam logic [1:0] MODE00 = 2'b00;
    localparam logic [1:0] MODE01 = 2'b01;
    localparam logic [1:0] MODE10 = 2'b10;
    localparam logic [1:0] MODE11 = 2'b11;

    // Data is sampled on the rising SCK edge when CKP and CPH agree.
    function automatic logic sample_on_rising(input logic ckp, input logic cph);
        logic r;
        case ({ckp, cph})
            MODE00, MODE11: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with rise/fall detection
// against the previous synchronised value.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign dout = chain[SYNC_STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/spi_receiver_param.sv
// Parametrised SPI slave: any frame width, selectable bit order, all four
// CKP/CPH modes, buffered transmit word, abort and underrun reporting.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | SS released; MISO held at 0, waiting for SS to fall
//   LOAD  | one cycle: copy holding register (or 0 on underrun) to tx shifter
//   SHIFT | shifting bits on SCK edges; word completion and back-to-back reload
module spi_receiver_param
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CKP,
    input  logic                  CPH,
    input  logic                  SCK,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  abort,
    output logic                  underrun
);

    localparam int              CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_WIDTH);

    state_t                 state, state_nxt;
    logic                   sck_s, sck_rise, sck_fall;
    logic                   ss_s, ss_rise_unused, ss_fall_unused;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi_s;
    logic [DATA_WIDTH-1:0]  hold_q, tx_sr, rx_sr, copy_word;
    logic                   hold_full;
    logic [CW-1:0]          cnt;
    logic                   first_shift;
    logic                   miso_q;
    logic                   sample_rise, sample_edge, shift_edge;
    logic                   copy, reload, word_done, abort_c, leave;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    // Incoming bits enter from the end opposite the bit order so the first
    // bit ends up in its proper position after DATA_WIDTH shifts.
    function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b);
        return LSB_FIRST ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
    endfunction

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .rst  (rst),
        .din  (SCK),
        .dout (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // SS resets to the released level so reset never looks like a frame start.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk  (clk),
        .rst  (rst),
        .din  (SS),
        .dout (ss_s),
        .rise (ss_rise_unused),
        .fall (ss_fall_unused)
    );

    assign mosi_s      = mosi_chain[SYNC_STAGES-1];
    assign sample_rise = sample_on_rising(CKP, CPH);
    assign sample_edge = sample_rise ? sck_rise : sck_fall;
    assign shift_edge  = sample_rise ? sck_fall : sck_rise;
    assign copy_word   = hold_full ? hold_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        copy      = 1'b0;
        reload    = 1'b0;
        word_done = 1'b0;
        abort_c   = 1'b0;
        leave     = 1'b0;
        case (state)
            IDLE: begin
                if (!ss_s) state_nxt = LOAD;
            end
            LOAD: begin
                copy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == CNT_FULL) begin
                    word_done = 1'b1;
                    if (ss_s) begin
                        leave     = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        reload = 1'b1;
                        copy   = 1'b1;
                    end
                end else if (ss_s) begin
                    leave     = 1'b1;
                    abort_c   = (cnt != '0);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign tx_ready = ~hold_full;
    assign MISO     = miso_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_chain  <= '0;
            hold_q      <= '0;
            hold_full   <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            abort       <= 1'b0;
            underrun    <= 1'b0;
            cnt         <= '0;
            first_shift <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
            rx_valid   <= word_done;
            abort      <= abort_c;
            underrun   <= copy & ~hold_full;

            if (word_done) rx_data <= rx_sr;

            // A copy only happens from a full register, and a write only into
            // an empty one, so a write during an underrun copy stays held.
            if (copy && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_load && !hold_full) begin
                hold_q    <= tx_data;
                hold_full <= 1'b1;
            end

            if (copy) begin
                tx_sr       <= copy_word;
                cnt         <= '0;
                // On a reload the next shift edge (trailing edge for CPH=0,
                // leading edge for CPH=1) must present bit 0, not advance.
                first_shift <= reload | CPH;
                if (!CPH) miso_q <= first_bit(copy_word);
            end else if (leave) begin
                cnt         <= '0;
                first_shift <= 1'b0;
                miso_q      <= 1'b0;
            end else if (state == SHIFT) begin
                if (sample_edge) begin
                    rx_sr <= rx_shift(rx_sr, mosi_s);
                    cnt   <= cnt + CW'(1);
                end else if (shift_edge) begin
                    if (first_shift) begin
                        miso_q      <= first_bit(tx_sr);
                        first_shift <= 1'b0;
                    end else begin
                        tx_sr  <= tx_advance(tx_sr);
                        miso_q <= first_bit(tx_advance(tx_sr));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_receiver_param.sv
// Bench for spi_receiver_param: an 8-bit LSB-first and a 16-bit MSB-first
// instance driven by a bit-level SPI master against a holding-register model.
module tb_spi_receiver_param;

    localparam int H = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ckpA, cphA, sckA, ssA, mosiA, misoA, txlA, rdyA, rxvA, busyA, abA, unA;
    logic [7:0]  txdA, rxdA;
    logic        ckpB, cphB, sckB, ssB, mosiB, misoB, txlB, rdyB, rxvB, busyB, abB, unB;
    logic [15:0] txdB, rxdB;

    int checks = 0;
    int failures = 0;

    int          rxv_n[2];
    int          ab_n[2];
    int          und_n[2];
    logic [15:0] m_hold[2];
    bit          m_full[2];

    spi_receiver_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .CKP(ckpA), .CPH(cphA), .SCK(sckA), .SS(ssA), .MOSI(mosiA),
        .MISO(misoA), .tx_data(txdA), .tx_load(txlA), .tx_ready(rdyA), .rx_data(rxdA),
        .rx_valid(rxvA), .busy(busyA), .abort(abA), .underrun(unA));

    spi_receiver_param #(.DATA_WIDTH(16), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .CKP(ckpB), .CPH(cphB), .SCK(sckB), .SS(ssB), .MOSI(mosiB),
        .MISO(misoB), .tx_data(txdB), .tx_load(txlB), .tx_ready(rdyB), .rx_data(rxdB),
        .rx_valid(rxvB), .busy(busyB), .abort(abB), .underrun(unB));

    always @(negedge clk) begin
        if (rxvA) rxv_n[0]++;
        if (rxvB) rxv_n[1]++;
        if (abA)  ab_n[0]++;
        if (abB)  ab_n[1]++;
        if (unA)  und_n[0]++;
        if (unB)  und_n[1]++;
    end

    function automatic logic get_miso(input int inst);
        return (inst == 0) ? misoA : misoB;
    endfunction
    function automatic logic get_rdy(input int inst);
        return (inst == 0) ? rdyA : rdyB;
    endfunction
    function automatic logic get_busy(input int inst);
        return (inst == 0) ? busyA : busyB;
    endfunction
    function automatic logic [15:0] get_rx(input int inst);
        return (inst == 0) ? {8'h00, rxdA} : rxdB;
    endfunction
    function automatic logic [15:0] wmask(input int inst);
        return (inst == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    task automatic toggle_sck(input int inst);
        if (inst == 0) sckA = ~sckA; else sckB = ~sckB;
    endtask
    task automatic drv_ss(input int inst, input logic v);
        if (inst == 0) ssA = v; else ssB = v;
    endtask
    task automatic drv_mosi(input int inst, input logic v);
        if (inst == 0) mosiA = v; else mosiB = v;
    endtask

    task automatic set_mode(input int inst, input logic ckp, input logic cph);
        @(negedge clk);
        if (inst == 0) begin ckpA = ckp; cphA = cph; sckA = ckp; end
        else           begin ckpB = ckp; cphB = cph; sckB = ckp; end
        repeat (6) @(negedge clk);
    endtask

    // Writes the holding register; the model accepts only into an empty register.
    task automatic hold_load(input int inst, input logic [15:0] d);
        @(negedge clk);
        if (inst == 0) begin txdA = d[7:0]; txlA = 1'b1; end
        else           begin txdB = d;      txlB = 1'b1; end
        if (!m_full[inst]) begin
            m_hold[inst] = d & wmask(inst);
            m_full[inst] = 1'b1;
        end
        @(negedge clk);
        txlA = 1'b0;
        txlB = 1'b0;
    endtask

    task automatic model_start(input int inst, output logic [15:0] exp_w, output int exp_und);
        exp_w        = m_full[inst] ? m_hold[inst] : 16'h0;
        exp_und      = m_full[inst] ? 0 : 1;
        m_full[inst] = 1'b0;
    endtask

    // SPI master: sends nbits of mosi_w in the instance's bit order and
    // collects MISO at each sample edge into the matching bit position.
    task automatic xfer(input int inst, input logic [15:0] mosi_w, input int nbits,
                        input bit keep_ss, output logic [15:0] miso_w,
                        output int und_delta, output logic rdy_load);
        int   w;
        bit   lsb;
        logic cph;
        int   u0;
        int   idx;
        w   = (inst == 0) ? 8 : 16;
        lsb = (inst == 0);
        cph = (inst == 0) ? cphA : cphB;
        u0  = und_n[inst];
        drv_ss(inst, 1'b0);
        if (!cph) drv_mosi(inst, mosi_w[lsb ? 0 : w-1]);
        repeat (12) @(negedge clk);
        und_delta = und_n[inst] - u0;
        rdy_load  = get_rdy(inst);
        miso_w    = 16'h0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : w-1-i;
            if (!cph) begin
                miso_w[idx] = get_miso(inst);
                toggle_sck(inst);
                repeat (H) @(negedge clk);
                toggle_sck(inst);
                if (i + 1 < w) drv_mosi(inst, mosi_w[lsb ? i+1 : w-2-i]);
                repeat (H) @(negedge clk);
            end else begin
                toggle_sck(inst);
                drv_mosi(inst, mosi_w[idx]);
                repeat (H) @(negedge clk);
                miso_w[idx] = get_miso(inst);
                toggle_sck(inst);
                repeat (H) @(negedge clk);
            end
        end
        if (!keep_ss) begin
            drv_ss(inst, 1'b1);
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({misoA, rdyA, rxdA, rxvA, busyA, abA, unA} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
            failures++;
            $display("FAIL reset_a: got %b expected %b",
                     {misoA, rdyA, rxdA, rxvA, busyA, abA, unA}, {1'b0, 1'b1, 8'h00, 4'b0000});
        end
        checks++;
        if ({misoB, rdyB, rxdB, rxvB, busyB, abB, unB} !== {1'b0, 1'b1, 16'h0000, 4'b0000}) begin
            failures++;
            $display("FAIL reset_b: got %b expected %b",
                     {misoB, rdyB, rxdB, rxvB, busyB, abB, unB}, {1'b0, 1'b1, 16'h0000, 4'b0000});
        end
    endtask

    // One complete frame with full result checking.
    task automatic frame_check(input string name, input int inst, input logic [15:0] mosi_w);
        logic [15:0] miso_w, exp_w;
        int          und_d, exp_und, v0;
        logic        rdy_l;
        mosi_w = mosi_w & wmask(inst);
        v0 = rxv_n[inst];
        model_start(inst, exp_w, exp_und);
        xfer(inst, mosi_w, (inst == 0) ? 8 : 16, 1'b0, miso_w, und_d, rdy_l);
        checks++;
        if (miso_w !== exp_w) begin
            failures++;
            $display("FAIL %s_miso: got %h expected %h", name, miso_w, exp_w);
        end
        checks++;
        if (get_rx(inst) !== mosi_w) begin
            failures++;
            $display("FAIL %s_rx: got %h expected %h", name, get_rx(inst), mosi_w);
        end
        checks++;
        if (rxv_n[inst] - v0 != 1) begin
            failures++;
            $display("FAIL %s_rxvalid: got %0d pulses expected 1", name, rxv_n[inst] - v0);
        end
        checks++;
        if (und_d != exp_und) begin
            failures++;
            $display("FAIL %s_underrun: got %0d expected %0d", name, und_d, exp_und);
        end
        checks++;
        if (rdy_l !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_after_load: got %b expected 1", name, rdy_l);
        end
    endtask

    task automatic test_mode00_lsb();
        set_mode(0, 1'b0, 1'b0);
        hold_load(0, 16'h00A5);
        checks++;
        if (rdyA !== 1'b0) begin
            failures++;
            $display("FAIL mode00_ready_drop: got %b expected 0", rdyA);
        end
        frame_check("mode00", 0, 16'h003C);
    endtask

    task automatic test_mode11_msb();
        set_mode(1, 1'b1, 1'b1);
        hold_load(1, 16'hBEEF);
        frame_check("mode11", 1, 16'h1234);
    endtask

    task automatic test_modes_01_10();
        set_mode(0, 1'b0, 1'b1);
        hold_load(0, 16'h0081);
        frame_check("mode01", 0, 16'h007E);
        set_mode(0, 1'b1, 1'b0);
        hold_load(0, 16'h007E);
        frame_check("mode10", 0, 16'h0081);
    endtask

    task automatic test_ignored_load();
        set_mode(1, 1'b1, 1'b0);
        hold_load(1, 16'hC0DE);
        hold_load(1, 16'h5555);
        checks++;
        if (rdyB !== 1'b0) begin
            failures++;
            $display("FAIL ignored_load_ready: got %b expected 0", rdyB);
        end
        frame_check("ignored_load", 1, 16'hA0F1);
    endtask

    task automatic test_back_to_back(input int inst, input logic ckp, input logic cph,
                                     input logic [15:0] w1, input logic [15:0] w2);
        logic [15:0] m1, m2, e1, e2, r1, r2;
        int          u, eu, v0;
        logic        rl;
        r1 = $urandom() & wmask(inst);
        r2 = $urandom() & wmask(inst);
        set_mode(inst, ckp, cph);
        hold_load(inst, w1);
        v0 = rxv_n[inst];
        model_start(inst, e1, eu);
        fork
            xfer(inst, r1, (inst == 0) ? 8 : 16, 1'b1, m1, u, rl);
            begin
                repeat (30) @(negedge clk);
                hold_load(inst, w2);
            end
        join
        checks++;
        if (get_rx(inst) !== r1) begin
            failures++;
            $display("FAIL b2b_rx1: got %h expected %h", get_rx(inst), r1);
        end
        model_start(inst, e2, eu);
        xfer(inst, r2, (inst == 0) ? 8 : 16, 1'b0, m2, u, rl);
        checks++;
        if ({m1, m2} !== {e1, e2}) begin
            failures++;
            $display("FAIL b2b_miso: got %h %h expected %h %h", m1, m2, e1, e2);
        end
        checks++;
        if (get_rx(inst) !== r2) begin
            failures++;
            $display("FAIL b2b_rx2: got %h expected %h", get_rx(inst), r2);
        end
        checks++;
        if (rxv_n[inst] - v0 != 2) begin
            failures++;
            $display("FAIL b2b_rxvalid: got %0d pulses expected 2", rxv_n[inst] - v0);
        end
    endtask

    task automatic test_underrun();
        set_mode(0, 1'b0, 1'b0);
        frame_check("underrun", 0, 16'h00C3);
    endtask

    task automatic test_abort(input int inst, input logic ckp, input logic cph, input int nbits);
        logic [15:0] rx0, mw, ew;
        int          a0, v0, u, eu;
        logic        rl;
        set_mode(inst, ckp, cph);
        hold_load(inst, 16'h5C5C);
        rx0 = get_rx(inst);
        a0  = ab_n[inst];
        v0  = rxv_n[inst];
        model_start(inst, ew, eu);
        xfer(inst, 16'h9D9D & wmask(inst), nbits, 1'b0, mw, u, rl);
        checks++;
        if (ab_n[inst] - a0 != ((nbits > 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL abort_%0d_pulse: got %0d expected %0d", nbits, ab_n[inst] - a0,
                     (nbits > 0) ? 1 : 0);
        end
        checks++;
        if (get_rx(inst) !== rx0 || rxv_n[inst] != v0) begin
            failures++;
            $display("FAIL abort_%0d_rx: got %h/%0d expected %h/0", nbits, get_rx(inst),
                     rxv_n[inst] - v0, rx0);
        end
        checks++;
        if (get_busy(inst) !== 1'b0) begin
            failures++;
            $display("FAIL abort_%0d_busy: got %b expected 0", nbits, get_busy(inst));
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] mw, ew;
        int          u, eu, a0, v0;
        logic        rl;
        set_mode(0, 1'b0, 1'b0);
        hold_load(0, 16'h00E7);
        model_start(0, ew, eu);
        xfer(0, 16'h006B, 5, 1'b1, mw, u, rl);
        checks++;
        if (busyA !== 1'b1) begin
            failures++;
            $display("FAIL midreset_busy_before: got %b expected 1", busyA);
        end
        hold_load(0, 16'h0011);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({misoA, rdyA, rxdA, rxvA, busyA, abA, unA} !== {1'b0, 1'b1, 8'h00, 4'b0000}) begin
            failures++;
            $display("FAIL midreset_outputs: got %b expected %b",
                     {misoA, rdyA, rxdA, rxvA, busyA, abA, unA}, {1'b0, 1'b1, 8'h00, 4'b0000});
        end
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        a0 = ab_n[0];
        v0 = rxv_n[0];
        drv_ss(0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (ab_n[0] != a0 || rxv_n[0] != v0 || busyA !== 1'b0) begin
            failures++;
            $display("FAIL midreset_after: abort %0d rxvalid %0d busy %b expected 0 0 0",
                     ab_n[0] - a0, rxv_n[0] - v0, busyA);
        end
    endtask

    task automatic test_random();
        int inst;
        for (int k = 0; k < 8; k++) begin
            inst = $urandom_range(0, 1);
            set_mode(inst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) != 0) hold_load(inst, 16'($urandom()));
            frame_check("random", inst, 16'($urandom()));
        end
    endtask

    initial begin
        rst  = 1'b0;
        ckpA = 0; cphA = 0; sckA = 0; ssA = 1; mosiA = 0; txlA = 0; txdA = '0;
        ckpB = 0; cphB = 0; sckB = 0; ssB = 1; mosiB = 0; txlB = 0; txdB = '0;
        m_full[0] = 0; m_full[1] = 0; m_hold[0] = '0; m_hold[1] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        test_mode00_lsb();
        test_mode11_msb();
        test_modes_01_10();
        test_back_to_back(0, 1'b0, 1'b0, 16'h0011, 16'h0022);
        test_back_to_back(1, 1'b1, 1'b1, 16'hA1B2, 16'h3C4D);
        test_underrun();
        test_ignored_load();
        test_abort(0, 1'b0, 1'b0, 3);
        test_abort(1, 1'b1, 1'b1, 3);
        test_abort(0, 1'b0, 1'b1, 0);
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_receiver_param.md
Name: spi_receiver_param

Overview:
Parametrised SPI slave (receiver) that succeeds the fixed 8-bit receiver_SPI. It supports any frame width and a selectable bit order, with all four CKP/CPH modes handled correctly (sample on one SCK edge, drive on the other). It synchronises the asynchronous SPI pins into the clk domain and exchanges words with the core through a buffered transmit handshake and a received-word strobe. Adds frame abort on early SS release, back-to-back frames and tx underrun reporting, none of which the 8-bit block has.

Parameters:
DATA_WIDTH, 8, bits per frame (≥2).
LSB_FIRST, 1, 1 = shift LSB first on MOSI/MISO, 0 = MSB first.
SYNC_STAGES, 2, flip-flop stages on SCK, SS and MOSI (≥2).

Ports:
clk  in  1  system clock, sole clock.
rst  in  1  asynchronous, active-low reset.
CKP  in  1  SCK idle polarity; must be held stable while SS is low.
CPH  in  1  SCK phase; must be held stable while SS is low.
SCK  in  1  serial clock from transmitter, asynchronous to clk.
SS   in  1  active-low slave select, asynchronous.
MOSI in  1  serial data from transmitter.
MISO out 1  serial data to transmitter; driven 0 while SS is high.
tx_data  in  DATA_WIDTH  word to send in the next frame.
tx_load  in  1  write tx_data into the holding register; honoured only when tx_ready=1.
tx_ready out 1  holding register empty.
rx_data  out DATA_WIDTH  last complete received word; held until the next complete frame.
rx_valid out 1  one-cycle pulse when rx_data is updated.
busy     out 1  high in LOAD/SHIFT.
abort    out 1  one-cycle pulse when SS rises mid-frame.
underrun out 1  one-cycle pulse when a frame starts with the holding register empty.

Behaviour:
- Reset (rst=0, async): state=IDLE; MISO=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, abort=0, underrun=0; all shift registers and counters = 0.
- Sync: SCK, SS and MOSI each pass through SYNC_STAGES flip-flops. Edges are detected against the previous synchronised SCK value. Requirement: each SCK half-period ≥ SYNC_STAGES+3 clk periods.
- Edge selection: the sample edge is rising when CKP XOR CPH = 0, otherwise falling. The shift edge is the opposite edge.
- States: IDLE, LOAD, SHIFT.
- IDLE → LOAD when synchronised SS = 0.
- LOAD, one cycle:
  - tx shift register ← holding register and tx_ready ← 1 if the holding register is full.
  - Otherwise tx shift register ← 0 and underrun pulses.
  - Bit counter ← 0, then → SHIFT.
  - When CPH=0, MISO presents the first bit (selected by LSB_FIRST) at the end of LOAD.
- SHIFT:
  - Sample edge: the synchronised MOSI bit enters the rx shift register from the end opposite the bit order; counter +1.
  - Shift edge: the tx shift register advances and MISO takes the next bit. When CPH=1, the first shift edge presents bit 0 and no advance occurs beforehand.
  - When the counter reaches DATA_WIDTH on a sample edge, the next cycle does the following:
    - rx_data ← assembled word, with rx_valid pulsing in that same cycle.
    - If SS is still low, reload the tx shift register exactly as in LOAD (back-to-back frame) and reset the counter; stay in SHIFT.
- Abort: synchronised SS = 1 in SHIFT with 0 < counter < DATA_WIDTH → abort pulse, partial word discarded, rx_data unchanged, → IDLE.
- SS = 1 with counter = 0 or at a word boundary → IDLE with no abort.
- Holding register:
  - tx_load with tx_ready=1 writes it and drops tx_ready the next cycle.
  - tx_load with tx_ready=0 is ignored.
  - A simultaneous tx_load and LOAD copy: the copy takes the old content and the new word remains held (tx_ready stays 0).
- Counter width: $clog2(DATA_WIDTH+1). No wrap: the counter is always cleared at DATA_WIDTH.
- Reset mid-frame: immediate return to IDLE. The frame in progress is lost, with no rx_valid and no abort.

Decomposition:
- Package spi_pkg holds:
  - state encoding (IDLE/LOAD/SHIFT localparams);
  - mode constants MODE00..MODE11;
  - the function sample_on_rising(CKP, CPH).
- Sub-module spi_sync_edge (SYNC_STAGES parameter): synchroniser plus rise/fall detect. It is instantiated for SCK and SS; MOSI uses the synchroniser only.

Test Plan:
1. Mode 00, W=8, LSB_FIRST=1: load 0xA5, transmitter sends 0x3C → MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid pulses once; tx_ready returns to 1 after LOAD.
2. Mode 11, W=16, LSB_FIRST=0: load 0xBEEF, receive 0x1234 → MISO MSB first 0xBEEF; rx_data=0x1234.
3. Modes 01 and 10, W=8: exchange 0x81/0x7E → correct on both, each bit sampled on the proper edge.
4. Back-to-back: two words 0x11, 0x22 with SS held low, holding register refilled between them → two rx_valid pulses, MISO sends 0x11 then 0x22.
5. Underrun: SS falls with tx_ready=1 → underrun pulse, MISO=0 for all bits, rx still captured.
6. Abort and reset: SS rises after 3 bits → abort pulse, rx_data unchanged. rst=0 after 5 bits → all outputs at reset values immediately.
